// File: rtl/match_unit.sv
// match_unit: pipelined multi-channel masked identity comparator.
// Each channel holds a reference word, a don't-care mask and an enable.
// Keys are compared in stage 1. Stage 2 registers the qualified result,
// updates the sticky hit flags and updates the saturating hit counter.
module match_unit #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ld,
    input  logic [IDX_W-1:0]    i_ld_ch,
    input  logic [WIDTH-1:0]    i_ld_val,
    input  logic [WIDTH-1:0]    i_ld_mask,
    input  logic                i_ld_en,
    input  logic                i_key_valid,
    input  logic [WIDTH-1:0]    i_key,
    input  logic                i_sticky_clr,
    input  logic                i_cnt_clr,
    output logic                o_match_valid,
    output logic [CHANNELS-1:0] o_match_vec,
    output logic                o_match_any,
    output logic [IDX_W-1:0]    o_match_idx,
    output logic [CHANNELS-1:0] o_sticky,
    output logic [CNT_W-1:0]    o_hit_count,
    output logic                o_cnt_sat
);

    logic [WIDTH-1:0]    r_val  [CHANNELS];
    logic [WIDTH-1:0]    r_mask [CHANNELS];
    logic [CHANNELS-1:0] r_en;

    logic                r_s1_valid;
    logic [CHANNELS-1:0] r_s1_hit;

    logic                r_match_valid;
    logic [CHANNELS-1:0] r_match_vec;
    logic                r_match_any;
    logic [IDX_W-1:0]    r_match_idx;
    logic [CHANNELS-1:0] r_sticky;
    logic [CNT_W-1:0]    r_hit_count;

    logic                w_ld_legal;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_vec;
    logic                w_any;
    logic [IDX_W-1:0]    w_idx;

    // Channel numbers beyond CHANNELS-1 can exist when CHANNELS is not a power of two.
    assign w_ld_legal = ({1'b0, i_ld_ch} < (IDX_W + 1)'(CHANNELS));

    // Reference registers: one channel's val/mask/en load together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_val[i]  <= '0;
                r_mask[i] <= '0;
            end
            r_en <= '0;
        end else if (i_ld && w_ld_legal) begin
            r_val[i_ld_ch]  <= i_ld_val;
            r_mask[i_ld_ch] <= i_ld_mask;
            r_en[i_ld_ch]   <= i_ld_en;
        end
    end

    // Per-channel masked equality against the pre-edge reference registers.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_hit[i] = r_en[i] && (&(r_mask[i] | ~(i_key ^ r_val[i])));
        end
    end

    // Stage 1: capture the key qualifier and the raw channel hits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
        end else begin
            r_s1_valid <= i_key_valid;
            r_s1_hit   <= w_hit;
        end
    end

    // Gate the stage-1 hits with valid and find the lowest matching channel.
    always_comb begin
        w_vec = r_s1_hit & {CHANNELS{r_s1_valid}};
        w_any = |w_vec;
        w_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_vec[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // Stage 2 with sticky flags and hit counter; a clear never drops a coincident hit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_match_valid <= 1'b0;
            r_match_vec   <= '0;
            r_match_any   <= 1'b0;
            r_match_idx   <= '0;
            r_sticky      <= '0;
            r_hit_count   <= '0;
        end else begin
            r_match_valid <= r_s1_valid;
            r_match_vec   <= w_vec;
            r_match_any   <= w_any;
            r_match_idx   <= w_idx;
            r_sticky      <= (i_sticky_clr ? '0 : r_sticky) | w_vec;
            if (i_cnt_clr) begin
                r_hit_count <= CNT_W'(w_any);
            end else if (w_any && !(&r_hit_count)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

    assign o_match_valid = r_match_valid;
    assign o_match_vec   = r_match_vec;
    assign o_match_any   = r_match_any;
    assign o_match_idx   = r_match_idx;
    assign o_sticky      = r_sticky;
    assign o_hit_count   = r_hit_count;
    assign o_cnt_sat     = &r_hit_count;

endmodule

// File: doc/match_unit.md
# match_unit

Parametrised, pipelined multi-channel identity comparator with masking, per-channel enables, sticky hit flags and a saturating hit counter. It generalises the fixed 6-bit single-compare equality part to CHANNELS independently loadable reference words of WIDTH bits. It sits beside the address/map datapath and flags keys that match programmed values, for example breakpoint or trap addresses. All state is owned by one clock domain.

## Interface
Parameters:
- WIDTH, 6, compared word width (≥1)
- CHANNELS, 4, number of reference channels (≥1)
- CNT_W, 8, hit counter width
- IDX_W, max(1, clog2(CHANNELS)), channel index width (derived)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ld  in  1  load strobe for one channel's reference registers
- ld_ch  in  IDX_W  channel being loaded; values ≥ CHANNELS are ignored
- ld_val  in  WIDTH  reference value
- ld_mask  in  WIDTH  don't-care mask; 1 = bit ignored
- ld_en  in  1  channel enable
- key_valid  in  1  key qualifier
- key  in  WIDTH  word to compare
- sticky_clr  in  1  clear all sticky flags
- cnt_clr  in  1  clear hit counter
- match_valid  out  1  result qualifier, 2 cycles after key_valid
- match_vec  out  CHANNELS  per-channel match
- match_any  out  1  OR of match_vec
- match_idx  out  IDX_W  lowest matching channel index; 0 when none match
- sticky  out  CHANNELS  accumulated per-channel hits
- hit_count  out  CNT_W  number of valid results with match_any
- cnt_sat  out  1  hit_count is all ones

## Operation
- Per channel: val, mask, and en registers. On ld with a legal ld_ch, all three load together at the edge. An illegal ld_ch is a no-op.
- Channel i matches when: en[i], and for every bit b, mask[i][b] OR key[b]==val[i][b]. With an all-ones mask, an enabled channel matches any valid key. A disabled channel never matches.
- Stage 1 (edge after key presented): registers s1_valid=key_valid, and s1_hit[i] = channel-i match computed against the reference registers as they stood before the edge.
  - A ld in the same cycle as key affects only later keys.
- Stage 2: registers match_valid=s1_valid and match_vec = s1_hit gated by s1_valid. It also registers match_any and match_idx, where match_idx uses a priority encoder with the lowest index winning.
- When match_valid=0: match_vec, match_any, and match_idx are all 0.
- sticky[i] is set on each edge where stage 2 loads match_vec[i]=1.
  - sticky_clr clears all sticky flags.
  - If sticky_clr coincides with a new hit, the hit bits end up set. No event is lost.
- hit_count increments on each edge where stage 2 loads a valid result with match_any=1. It holds at all ones (no wrap).
  - cnt_clr sets the count to 0.
  - If cnt_clr coincides with a hit, the count becomes 1.
- cnt_sat = &hit_count (combinational from the register).
- Reset clears all state: val, mask, en, pipeline, sticky, and hit_count all go to 0.

## Timing
- Reset values: match_valid=0, match_vec=0, match_any=0, match_idx=0, sticky=0, hit_count=0, cnt_sat=0 (1 only if CNT_W results in all-ones at 0, which is impossible for CNT_W≥1).
- Latency: a key at edge N produces a result visible after edge N+2. Throughput is one key per cycle with no stalls and no backpressure.
- sticky and hit_count reflect a result in the same cycle that match_valid shows it, i.e. both update on the edge that loads stage 2.
- Reset asserted mid-stream discards both pipeline stages. match_valid is 0 on the cycle after the reset edge, and no counts from flushed keys appear.
- A ld followed by a key on the next cycle compares against the new value.

## Test plan
- Reset, then load ch0 val=6'o25 mask=0 en=1, then key 6'o25 → two cycles later: match_valid=1, match_vec=4'b0001, match_idx=0, hit_count=1, sticky=4'b0001.
- Load ch1 and ch3 with val=6'o12, ch3 mask=6'o70. Send key 6'o52 → match_vec=4'b1000, idx=3. Send key 6'o12 → match_vec=4'b1010, idx=1.
- Present ld ch2 val=5 in the same cycle as key=5 (ch2 previously disabled) → no match. Next key=5 → match_vec[2]=1.
- Back-to-back keys 5,7,5,7 with only val=5 enabled → match_valid held at 1 for 4 cycles, match_any pattern 1,0,1,0, hit_count=2.
- CNT_W=2: six matching keys → hit_count sticks at 3 with cnt_sat=1. cnt_clr together with a hit → hit_count=1. sticky_clr together with a ch0 hit → sticky=4'b0001.
- Assert reset one cycle after a matching key → match_valid never rises, and hit_count and sticky stay 0.
